// File: rtl/fp_div_pkg.sv
// Shared constants and types for the radix-4 restoring mantissa divider.
package fp_div_pkg;

    localparam int FRAC_W_DEF = 23;
    localparam int QUOT_W_DEF = FRAC_W_DEF + 2;

    // Two quotient bits per cycle, FRAC_W+3 bits in total: ceil((frac_w+3)/2).
    function automatic int iter_cnt(input int frac_w);
        return (frac_w + 4) / 2;
    endfunction

    localparam int ITER_CNT = iter_cnt(FRAC_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring division step: conditional subtract, then shift left.
module div_step #(
    parameter int W = 25
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic         o_q
);

    logic [W-1:0] w_diff;

    assign o_q    = (i_rem >= i_div);
    assign w_diff = o_q ? (i_rem - i_div) : i_rem;
    // After the subtract w_diff < divisor, so the dropped MSB is always 0.
    assign o_rem  = {w_diff[W-2:0], 1'b0};

endmodule

// File: rtl/divider.sv
// Sequential 1.f / 1.f mantissa divider, two quotient bits per clock, truncated result.
// Define DIVIDER_STICKY_EN to add the registered inexact flag output "sticky".
module divider
    import fp_div_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic [FRAC_W-1:0] dividend,
    input  logic [FRAC_W-1:0] divisor,
    output logic [FRAC_W+1:0] quotient,
    output logic              finish
`ifdef DIVIDER_STICKY_EN
    ,
    output logic              sticky
`endif
);

    localparam int QUOT_W = FRAC_W + 2;
    localparam int REM_W  = FRAC_W + 2;
    localparam int ITER   = iter_cnt(FRAC_W);
    localparam int ACC_W  = 2 * ITER;
    localparam int LOW_W  = ACC_W - QUOT_W;
    localparam int CNT_W  = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    div_state_t          r_state;
    div_state_t          w_state_next;
    logic                w_capture;
    logic                w_complete;

    logic [FRAC_W:0]     r_div;
    logic [REM_W-1:0]    r_rem;
    logic [ACC_W-3:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [QUOT_W-1:0]   r_quotient;
    logic                r_finish;

    logic [REM_W-1:0]    w_rem1;
    logic [REM_W-1:0]    w_rem2;
    logic                w_q1;
    logic                w_q2;
    logic [ACC_W-1:0]    w_acc_next;

    div_step #(.W(REM_W)) u_step0 (
        .i_rem (r_rem),
        .i_div ({1'b0, r_div}),
        .o_rem (w_rem1),
        .o_q   (w_q1)
    );

    div_step #(.W(REM_W)) u_step1 (
        .i_rem (w_rem1),
        .i_div ({1'b0, r_div}),
        .o_rem (w_rem2),
        .o_q   (w_q2)
    );

    assign w_acc_next = {r_acc, w_q1, w_q2};

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_capture    = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_complete   = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (en) begin
                    w_capture    = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_div      <= '0;
            r_rem      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_quotient <= '0;
            r_finish   <= 1'b0;
        end else begin
            r_finish <= w_complete;
            if (w_capture) begin
                r_div <= {1'b1, divisor};
                r_rem <= {1'b0, 1'b1, dividend};
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == RUN && en) begin
                r_rem <= w_rem2;
                r_acc <= w_acc_next[ACC_W-3:0];
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_complete) r_quotient <= w_acc_next[ACC_W-1 -: QUOT_W];
        end
    end

    assign quotient = r_quotient;
    assign finish   = r_finish;

`ifdef DIVIDER_STICKY_EN
    logic r_sticky;

    // Inexact when the final remainder or any discarded quotient bit is nonzero.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst)           r_sticky <= 1'b0;
        else if (w_complete) r_sticky <= (|w_rem2) | (|w_acc_next[LOW_W-1:0]);
    end

    assign sticky = r_sticky;
`endif

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the mantissa divider (latency, results, back-to-back, reset, abort).
module tb_divider;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en;
    logic [22:0] dividend;
    logic [22:0] divisor;
    logic [24:0] quotient;
    logic        finish;
`ifdef DIVIDER_STICKY_EN
    logic        sticky;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    divider u_dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .finish   (finish)
`ifdef DIVIDER_STICKY_EN
        ,
        .sticky   (sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called right after a capture edge; scrambles operands during RUN and
    // returns at the negedge of the finish cycle.
    task automatic wait_done(input string tag, input logic [24:0] exp_q, input logic exp_s);
        int  edges;
        bit  seen;
        edges = 1;
        seen  = 1'b0;
        while (edges < 40) begin
            @(negedge clk);
            if (finish) begin
                seen = 1'b1;
                break;
            end
            dividend = 23'($urandom);
            divisor  = 23'($urandom);
            @(posedge clk);
            edges++;
        end
        check({tag, " seen"}, 32'(seen), 32'd1);
        check({tag, " lat"}, edges, 32'd14);
        check({tag, " q"}, 32'(quotient), 32'(exp_q));
`ifdef DIVIDER_STICKY_EN
        check({tag, " sticky"}, 32'(sticky), 32'(exp_s));
`else
        if (exp_s === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic single_op(input string tag, input logic [22:0] dvd, input logic [22:0] dvs,
                             input logic [24:0] exp_q, input logic exp_s);
        @(negedge clk);
        en       = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        wait_done(tag, exp_q, exp_s);
        en = 1'b0;
        @(negedge clk);
        check({tag, " pulse end"}, 32'(finish), 32'd0);
    endtask

    initial begin
        int pulses;
        n_rst    = 1'b1;
        en       = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("reset q", 32'(quotient), 32'd0);
        check("reset finish", 32'(finish), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;

        single_op("1/1",        23'h000000, 23'h000000, 25'h1000000, 1'b0);
        single_op("1.5/1",      23'h400000, 23'h000000, 25'h1800000, 1'b0);
        single_op("1/1.5",      23'h000000, 23'h400000, 25'h0AAAAAA, 1'b1);
        single_op("max/1",      23'h7FFFFF, 23'h000000, 25'h1FFFFFE, 1'b0);
        single_op("1/max",      23'h000000, 23'h7FFFFF, 25'h0800000, 1'b1);

        // Back-to-back with en held high; new operands presented in each DONE cycle.
        @(negedge clk);
        en       = 1'b1;
        dividend = 23'h6A7EFA;
        divisor  = 23'h000000;
        @(posedge clk);
        wait_done("b2b 1.832/1", 25'h1D4FDF4, 1'b0);
        dividend = 23'h7FFFFF;
        divisor  = 23'h7FFFFE;
        @(posedge clk);
        wait_done("b2b max/max-1", 25'h1000001, 1'b1);
        dividend = 23'h600000;
        divisor  = 23'h200000;
        @(posedge clk);
        wait_done("b2b 1.75/1.25", 25'h1666666, 1'b1);
        en = 1'b0;
        @(negedge clk);
        check("b2b pulse end", 32'(finish), 32'd0);

        // Reset in the middle of RUN.
        @(negedge clk);
        en       = 1'b1;
        dividend = 23'h400000;
        divisor  = 23'h000000;
        @(posedge clk);
        repeat (5) @(negedge clk);
        n_rst = 1'b1;
        en    = 1'b0;
        #1;
        check("midrun rst q", 32'(quotient), 32'd0);
        check("midrun rst finish", 32'(finish), 32'd0);
        @(negedge clk);
        n_rst = 1'b0;
        single_op("post-rst 1.75/1.25", 23'h600000, 23'h200000, 25'h1666666, 1'b1);

        // Drop en mid-run: no pulse, result unchanged.
        @(negedge clk);
        en       = 1'b1;
        dividend = 23'h000000;
        divisor  = 23'h000000;
        @(posedge clk);
        repeat (5) @(negedge clk);
        en     = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (finish) pulses++;
        end
        check("abort pulses", pulses, 32'd0);
        check("abort q held", 32'(quotient), 32'h1666666);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential mantissa divider for the single-precision FP datapath.
- Takes two 23-bit fraction fields with an implicit leading 1 (values 1.f in [1,2)) and produces a truncated 25-bit quotient in [0.5,2).
- Radix-4 restoring iteration: two quotient bits per clock, 14-cycle operation.
- Sits between exponent/sign handling and the normaliser/rounder of the FP divide unit.

Parameters:
- FRAC_W, 23, fraction width of each operand. Quotient width is FRAC_W+2; iteration count is ceil((FRAC_W+3)/2) = 13.

Ports:
- clk  input  1  single clock, rising-edge.
- n_rst  input  1  asynchronous, active-high reset. n_rst=1 resets despite the name.
- en  input  1  run enable; operands are captured on an edge where en=1 and the block is IDLE or DONE.
- dividend  input  FRAC_W  fraction of dividend; A = {1'b1, dividend}.
- divisor  input  FRAC_W  fraction of divisor; B = {1'b1, divisor}.
- quotient  output  FRAC_W+2  floor(A*2^(FRAC_W+1)/B); bit 24 is the integer bit, bits 23:0 are the fraction.
- finish  output  1  one-cycle pulse; quotient is valid from this cycle onward.

Behaviour:
- Reset (async, n_rst=1): state=IDLE, quotient=0, finish=0, all internal registers 0. Reset mid-operation aborts the division; nothing partial is output.
- States: IDLE, RUN, DONE.
- IDLE: when en=1, register A, B, partial remainder R=A, counter=0, then go to RUN.
- RUN: each cycle performs two cascaded restoring steps:
  - Step: compare R with B. If R>=B, set R=R-B and q bit=1; else q bit=0. Then R=R<<1.
  - Shift 2 quotient bits into a 26-bit accumulator; increment counter.
- After 13 RUN cycles (26 bits = floor(A*2^25/B)):
  - quotient <= accumulator[25:1], which equals floor(A*2^24/B).
  - Go to DONE.
- DONE: finish=1 for exactly this cycle.
  - If en=1, capture the current operands and go directly to RUN (back-to-back; period 14 cycles).
  - Else go to IDLE.
- Latency: capture edge to finish-high is 14 clock edges.
- en=0 during RUN aborts to IDLE; quotient keeps its previous value and finish stays 0.
- Operands are sampled only at capture; input changes during RUN are ignored.
- quotient holds its last result until the next completion or reset. finish=0 in IDLE and RUN.
- Range: A/B is in (0.5,2), so quotient is in [2^23, 2^25-2]. No overflow is possible and there is no divide-by-zero case (the implicit 1 guarantees B>=1).
- Remainder width FRAC_W+2 bits is sufficient because R<2B is maintained.
- Truncation only; rounding is done downstream.

Optional Feature:
- Macro DIVIDER_STICKY_EN.
- Defined: adds output port sticky (1 bit), registered together with quotient.
  - sticky=1 iff the final remainder is nonzero or accumulator[0]=1, i.e. the result is inexact.
  - sticky resets to 0 and pulses/holds exactly like quotient.
- Undefined: no sticky port and no extra logic.

Decomposition:
- Package fp_div_pkg holds:
  - FRAC_W default
  - ITER_CNT (13)
  - state enum type div_state_t {IDLE, RUN, DONE}
  - quotient width localparam
- Natural sub-module: div_step, a combinational single restoring step taking (R, B) and returning (R_next, q_bit). It is instantiated twice in cascade per cycle.

Test Plan:
- en=1, dividend=0, divisor=0 (1.0/1.0) -> finish pulses 14 cycles after capture; quotient=25'h1000000.
- dividend=23'h400000 (1.5), divisor=0 -> quotient=25'h1800000.
- dividend=0, divisor=23'h400000 (1.0/1.5) -> quotient=25'h0AAAAAA.
- dividend=23'h7FFFFF, divisor=0 -> quotient=25'h1FFFFFE.
- dividend=0, divisor=23'h7FFFFF -> quotient=25'h0800000.
- en held 1 while operands change every 14 cycles (e.g. 1.832/1.0, then 1.999999/1.9999) -> finish pulses every 14 cycles, each result matches floor(A*2^24/B) for the operands present at its capture edge.
- Assert n_rst during RUN -> quotient=0 and finish=0 immediately; after release with en=1 a fresh 14-cycle operation completes correctly.
- Drop en during RUN -> no finish pulse; quotient is unchanged.
